// File: rtl/cic_interpolator_var.sv
// cic_interpolator_var: CIC interpolator with a run-time ratio, rounding, shift and saturation
//   clk/reset_n        output-rate clock, async active-low reset
//   enable             run; low clears the datapath and latches ratio/shift
//   ratio, shift       interpolation ratio R and output right shift (latched while idle)
//   in_data/in_valid/in_ready   input sample handshake, one strobe every R clocks
//   out_data/out_valid one output sample per clock while running
//   underrun/clr_underrun       sticky missed-sample flag and its clear
module cic_interpolator_var #(
  parameter int ISZ = 16,
  parameter int OSZ = 16,
  parameter int NUM_STAGES = 3,
  parameter int DIFF_DLY = 1,
  parameter int RMAX_LOG2 = 5,
  localparam int RMAX = 2 ** RMAX_LOG2,
  localparam int ASZ = ISZ + NUM_STAGES * (RMAX_LOG2 + $clog2(DIFF_DLY)),
  localparam int SHW = $clog2(ASZ)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [RMAX_LOG2:0]   ratio,
  input  logic [SHW-1:0]       shift,
  input  logic [ISZ-1:0]       in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OSZ-1:0]       out_data,
  output logic                 out_valid,
  output logic                 underrun,
  input  logic                 clr_underrun
);
  localparam int N = NUM_STAGES;
  localparam int M = DIFF_DLY;
  localparam int CW = ISZ + NUM_STAGES;
  localparam logic signed [ASZ:0] OMAX = (ASZ + 1)'(2 ** (OSZ - 1) - 1);
  localparam logic signed [ASZ:0] OMIN = ~OMAX;
  logic [RMAX_LOG2:0] rl, p;
  logic [SHW-1:0] sh;
  logic [N:0] stb;
  logic go;
  logic [2*N-1:0] vp;
  logic signed [CW-1:0] comb [N+1];
  logic signed [CW-1:0] dly [N][M];
  logic signed [ASZ-1:0] acc [N];
  logic signed [ASZ:0] rnd, ext, y;
  logic [OSZ-1:0] sat;
  always_comb begin
    rnd = (sh == '0) ? '0 : (ASZ + 1)'(1) << (sh - 1'b1);
    ext = (ASZ + 1)'(acc[N-1]) + rnd;
    y = ext >>> sh;
    sat = (y > OMAX) ? {1'b0, {(OSZ-1){1'b1}}} : (y < OMIN) ? {1'b1, {(OSZ-1){1'b0}}} : y[OSZ-1:0];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rl <= (RMAX_LOG2 + 1)'(1);
      sh <= '0;
    end else if (!enable) begin
      rl <= (ratio == '0) ? (RMAX_LOG2 + 1)'(1) : (ratio > (RMAX_LOG2 + 1)'(RMAX)) ? (RMAX_LOG2 + 1)'(RMAX) : ratio;
      sh <= (shift > SHW'(ASZ - 1)) ? SHW'(ASZ - 1) : shift;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      p <= '0;
      in_ready <= 1'b0;
      stb <= '0;
      go <= 1'b0;
      vp <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      for (int k = 0; k <= N; k++) comb[k] <= '0;
      for (int k = 0; k < N; k++) begin
        acc[k] <= '0;
        for (int m = 0; m < M; m++) dly[k][m] <= '0;
      end
    end else if (!enable) begin
      p <= '0;
      in_ready <= 1'b0;
      stb <= '0;
      go <= 1'b0;
      vp <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      for (int k = 0; k <= N; k++) comb[k] <= '0;
      for (int k = 0; k < N; k++) begin
        acc[k] <= '0;
        for (int m = 0; m < M; m++) dly[k][m] <= '0;
      end
    end else begin
      p <= (p == rl - 1'b1) ? '0 : p + 1'b1;
      in_ready <= (p == '0);
      // stb[k-1] fires comb k; stb[N] marks the zero-stuffed sample entering integrator 0
      stb <= {stb[N-1:0], in_ready};
      // on underrun comb[0] simply holds, so the previous sample is re-used
      if (in_ready && in_valid) comb[0] <= CW'($signed(in_data));
      for (int k = 1; k <= N; k++)
        if (stb[k-1]) begin
          comb[k] <= comb[k-1] - dly[k-1][M-1];
          dly[k-1][0] <= comb[k-1];
          for (int m = 1; m < M; m++) dly[k-1][m] <= dly[k-1][m-1];
        end
      acc[0] <= acc[0] + (stb[N] ? ASZ'(comb[N]) : '0);
      for (int j = 1; j < N; j++) acc[j] <= acc[j] + acc[j-1];
      // out_valid trails the first accepted strobe by the full pipeline depth
      go <= go | in_ready;
      vp <= {vp[2*N-2:0], go};
      out_valid <= vp[2*N-1];
      out_data <= sat;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) underrun <= 1'b0;
    else if (enable && in_ready && !in_valid) underrun <= 1'b1;
    else if (clr_underrun) underrun <= 1'b0;
endmodule

// File: tb/tb_cic_interpolator_var.sv
// tb_cic_interpolator_var: directed bench for cic_interpolator_var (N=3, M=1, RMAX=32, 16-bit I/O)
module tb_cic_interpolator_var;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [5:0] ratio = 6'd1;
  logic [4:0] shift = 5'd0;
  logic [15:0] in_data = 16'd0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] out_data;
  logic out_valid;
  logic underrun;
  logic clr_underrun = 1'b0;
  int errors = 0;
  int checks = 0;
  cic_interpolator_var dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .ratio(ratio), .shift(shift),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .underrun(underrun), .clr_underrun(clr_underrun)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic idle(input int r, input int s);
    enable = 1'b0;
    ratio = 6'(r);
    shift = 5'(s);
    tick();
    tick();
  endtask
  function automatic int od();
    return int'($signed(out_data));
  endfunction
  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'd0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b data=%0d urun=%b, want all 0", in_ready, out_valid, od(), underrun);
    end
    reset_n = 1'b1;
    tick();
  endtask
  task automatic test_impulse(input string tag);
    int imp [11] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};
    idle(4, 0);
    in_valid = 1'b1;
    in_data = 16'd0;
    enable = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s first_ready: got %b want 1", tag, in_ready); end
    in_data = 16'd1;
    tick();
    in_data = 16'd0;
    repeat (6) tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0) begin
      errors++;
      $display("FAIL %s pre_latency: vld=%b data=%0d want 0/0", tag, out_valid, od());
    end
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (od() !== imp[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL %s impulse[%0d]: data=%0d vld=%b want %0d/1", tag, i, od(), out_valid, imp[i]);
      end
    end
  endtask
  task automatic test_step();
    idle(4, 0);
    in_data = 16'd1;
    in_valid = 1'b1;
    enable = 1'b1;
    repeat (40) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od() !== 16) begin errors++; $display("FAIL step_dc: got %0d want 16", od()); end
      tick();
    end
    idle(4, 4);
    enable = 1'b1;
    repeat (40) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od() !== 1) begin errors++; $display("FAIL step_shift4: got %0d want 1", od()); end
      tick();
    end
  endtask
  task automatic test_saturation();
    int prev, glitch;
    idle(32, 0);
    in_data = 16'h7fff;
    in_valid = 1'b1;
    enable = 1'b1;
    repeat (200) tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (od() !== 32767) begin errors++; $display("FAIL sat_pos: got %0d want 32767", od()); end
      tick();
    end
    in_data = 16'h8000;
    prev = od();
    glitch = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (od() > prev) glitch++;
      prev = od();
    end
    checks++;
    if (glitch !== 0) begin errors++; $display("FAIL sat_monotone: %0d rising steps, want 0", glitch); end
    checks++;
    if (od() !== -32768) begin errors++; $display("FAIL sat_neg: got %0d want -32768", od()); end
  endtask
  task automatic test_handshake();
    int bad, dev;
    idle(8, 0);
    in_data = 16'd5;
    in_valid = 1'b1;
    enable = 1'b1;
    bad = 0;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (in_ready !== ((i - 1) % 8 == 0)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ready_period8: %0d wrong cycles, want 0", bad); end
    checks++;
    if (od() !== 320 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL hs_dc: data=%0d urun=%b want 320/0", od(), underrun);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hs_strobe: got %b want 1", in_ready); end
    in_valid = 1'b0;
    in_data = 16'd99;
    tick();
    in_valid = 1'b1;
    in_data = 16'd5;
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set: got %b want 1", underrun); end
    dev = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (od() !== 320) dev++;
    end
    checks++;
    if (dev !== 0) begin errors++; $display("FAIL underrun_repeat: %0d cycles off 320, want 0", dev); end
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clr: got %b want 0", underrun); end
    repeat (6) tick();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL hs_strobe2: got %b want 1", in_ready); end
    in_valid = 1'b0;
    clr_underrun = 1'b1;
    tick();
    in_valid = 1'b1;
    clr_underrun = 1'b0;
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set_wins: got %b want 1", underrun); end
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
  endtask
  task automatic test_ratio_clamp();
    int rv [2] = '{0, 63};
    int per [2] = '{1, 32};
    int win [2] = '{20, 96};
    int bad;
    for (int c = 0; c < 2; c++) begin
      idle(rv[c], 0);
      in_valid = 1'b1;
      in_data = 16'd0;
      enable = 1'b1;
      bad = 0;
      for (int i = 1; i <= win[c]; i++) begin
        tick();
        if (in_ready !== ((i - 1) % per[c] == 0)) bad++;
      end
      checks++;
      if (bad !== 0) begin errors++; $display("FAIL clamp_ratio%0d: %0d wrong cycles, want 0", rv[c], bad); end
    end
    idle(4, 0);
    enable = 1'b1;
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      ratio = 6'd8;
      if (in_ready !== ((i - 1) % 4 == 0)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ratio_held_running: %0d wrong cycles, want 0", bad); end
    enable = 1'b0;
    tick();
    tick();
    enable = 1'b1;
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      tick();
      if (in_ready !== ((i - 1) % 8 == 0)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL ratio_relatched: %0d wrong cycles, want 0", bad); end
  endtask
  task automatic test_back_to_back();
    int x [5] = '{3, -2, 7, 0, 5};
    int bad;
    idle(1, 0);
    in_valid = 1'b1;
    in_data = 16'd0;
    enable = 1'b1;
    tick();
    bad = 0;
    for (int m = 0; m < 14; m++) begin
      if (in_ready !== 1'b1) bad++;
      in_data = (m < 5) ? 16'(x[m]) : 16'd0;
      if (m >= 8) begin
        checks++;
        if (od() !== ((m - 8 < 5) ? x[m-8] : 0)) begin
          errors++;
          $display("FAIL r1_passthru[%0d]: got %0d want %0d", m - 8, od(), (m - 8 < 5) ? x[m-8] : 0);
        end
      end
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL r1_ready: %0d low cycles, want 0", bad); end
  endtask
  task automatic test_abort();
    idle(4, 0);
    in_data = 16'd1;
    in_valid = 1'b1;
    enable = 1'b1;
    repeat (40) tick();
    checks++;
    if (od() !== 16) begin errors++; $display("FAIL abort_pre: got %0d want 16", od()); end
    enable = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_enable: vld=%b data=%0d rdy=%b want 0/0/0", out_valid, od(), in_ready);
    end
    test_impulse("after_abort");
    idle(4, 0);
    in_data = 16'd1;
    enable = 1'b1;
    repeat (40) tick();
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'd0) begin
      errors++;
      $display("FAIL abort_reset: vld=%b data=%0d want 0/0", out_valid, od());
    end
    tick();
    enable = 1'b0;
    reset_n = 1'b1;
    test_impulse("after_reset");
  endtask
  initial begin
    test_reset();
    test_impulse("impulse");
    test_step();
    test_saturation();
    test_handshake();
    test_ratio_clamp();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
